// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : interrupt_sequencer
// Desc    : Edge-latched, lowest-index-first interrupt controller that forces
//           the program sequencer to a vector and returns on reti.
//           Optional macro NESTED_IRQ_EN: two-deep preemptive nesting.
// Revision: 1.0
// ============================================================================
module interrupt_sequencer #(
  parameter int         N_IRQ    = 4,
  parameter logic [3:0] VEC_BASE = 4'hC
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             irq_en,
  input  logic [7:0]       seq_next_addr,
  input  logic             reti,
  output logic             int_jmp,
  output logic [3:0]       int_addr,
  output logic             ret_jmp,
  output logic [7:0]       ret_addr,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VECTOR  = 2'd1,
    SERVICE = 2'd2,
    RETURN  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [N_IRQ-1:0] prev_req;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] cand;
  logic [1:0]       winner;
  logic [1:0]       cur_idx;
  logic             take;

  assign rise = irq_req & ~prev_req;
  assign cand = pending & ~irq_mask;
  assign take = irq_en & (|cand);

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    winner = 2'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) winner = 2'(i);
    end
  end

`ifdef NESTED_IRQ_EN
  logic [7:0]       stk_addr [2];
  logic [1:0]       stk_lvl  [2];
  logic [1:0]       sp;
  logic [N_IRQ-1:0] below;
  logic             preempt;

  always_comb begin
    below = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      below[i] = (2'(i) < cur_idx);
    end
  end

  // Any unmasked candidate below the active level means the lowest one is too.
  assign preempt = irq_en & (|(cand & below)) & (sp != 2'd2);
`endif

  always_ff @(posedge clk) begin
    if (sync_reset) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    int_jmp    = 1'b0;
    int_addr   = 4'h0;
    ret_jmp    = 1'b0;
    irq_ack    = '0;
    in_service = 1'b0;
    case (state)
      IDLE: begin
        if (take) next_state = VECTOR;
      end
      VECTOR: begin
        next_state = SERVICE;
        int_jmp    = 1'b1;
        int_addr   = VEC_BASE + {2'b00, cur_idx};
        in_service = 1'b1;
        for (int i = 0; i < N_IRQ; i++) begin
          irq_ack[i] = (cur_idx == 2'(i));
        end
      end
      SERVICE: begin
        in_service = 1'b1;
`ifdef NESTED_IRQ_EN
        if (reti)         next_state = RETURN;
        else if (preempt) next_state = VECTOR;
`else
        if (reti) next_state = RETURN;
`endif
      end
      RETURN: begin
        ret_jmp    = 1'b1;
        in_service = 1'b1;
`ifdef NESTED_IRQ_EN
        next_state = (sp == 2'd0) ? IDLE : SERVICE;
`else
        next_state = IDLE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      prev_req <= irq_req;
      pending  <= '0;
      cur_idx  <= 2'd0;
      ret_addr <= 8'h00;
`ifdef NESTED_IRQ_EN
      sp       <= 2'd0;
      for (int k = 0; k < 2; k++) begin
        stk_addr[k] <= 8'h00;
        stk_lvl[k]  <= 2'd0;
      end
`endif
    end else begin
      prev_req <= irq_req;
      // A fresh edge in the ack cycle must survive the clear.
      pending  <= (pending & ~irq_ack) | rise;
      if (state != VECTOR && next_state == VECTOR) cur_idx <= winner;
      if (state == VECTOR) ret_addr <= seq_next_addr;
`ifdef NESTED_IRQ_EN
      if (state == SERVICE && next_state == VECTOR) stk_lvl[sp[0]] <= cur_idx;
      if (state == VECTOR) begin
        stk_addr[sp[0]] <= seq_next_addr;
        sp              <= sp + 2'd1;
      end
      // Top of stack sits at sp-1, which for sp in {1,2} is sp[1].
      if (state == SERVICE && next_state == RETURN) begin
        ret_addr <= stk_addr[sp[1]];
        cur_idx  <= stk_lvl[sp[1]];
        sp       <= sp - 2'd1;
      end
`endif
    end
  end

endmodule
`default_nettype wire
